trap_peak_capture: RTL and testbench

- Downstream consumer of the trapezoidal filter output stream. Sits directly after the filter, before the histogram and readout logic.
- Detects each trapezoid by threshold crossing and samples the flat-top at a programmed offset. Emits one pulse-height word plus the crossing timestamp per accepted pulse on an AXI-Stream master with backpressure.
- Rejects pulses that fall below threshold before the sample point, and enforces a holdoff after each pulse.

---
 rtl/trap_pkg.sv | 25 ++
 rtl/trap_peak_capture_axis_out_reg.sv | 68 ++++++
 rtl/trap_peak_capture.sv | 175 +++++++++++++++++
 tb/tb_trap_peak_capture.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// trap_pkg: shared definitions for the trapezoid peak-capture block.
//   - default widths for data, delay/holdoff counters and timestamp
//   - FSM state encoding
//   - saturation limit and saturating increment helper for 32-bit counters
package trap_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CNT_WIDTH  = 14;
  localparam int DEF_TS_WIDTH   = 32;

  localparam logic [31:0] CNT_SAT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_WAIT_LOW = 2'd2,
    ST_HOLDOFF  = 2'd3
  } trap_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    if (en && (v != CNT_SAT)) return v + 32'd1;
    return v;
  endfunction

endpackage

// File: rtl/trap_peak_capture_axis_out_reg.sv
// axis_out_reg: single-entry AXI-Stream holding register.
//   clk, aresetn      clock, synchronous active-low reset
//   load              a new word is offered this cycle
//   load_data/user    the offered word
//   m_axis_*          AXI-Stream master side (tdata, tuser, tvalid, tready)
//   loaded            the offered word was written into the register
//   dropped           the offered word was discarded (register full, not draining)
module axis_out_reg
  import trap_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int USER_WIDTH = DEF_TS_WIDTH
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [USER_WIDTH-1:0] load_user,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  loaded,
  output logic                  dropped
);

  logic                  tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [USER_WIDTH-1:0] tuser_q, tuser_d;

  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    loaded   = 1'b0;
    dropped  = 1'b0;
    if (load) begin
      // A held word that is draining on this edge frees the slot for the new one.
      if (tvalid_q && !m_axis_tready) begin
        dropped = 1'b1;
      end else begin
        tvalid_d = 1'b1;
        tdata_d  = load_data;
        tuser_d  = load_user;
        loaded   = 1'b1;
      end
    end else if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= '0;
    end else begin
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;

endmodule

// File: rtl/trap_peak_capture.sv
// trap_peak_capture: detects trapezoids by threshold crossing, samples the
// flat-top a programmed number of valid samples after the crossing and emits
// energy + crossing timestamp on an AXI-Stream master.
//   clk, aresetn                 clock, synchronous active-low reset
//   s_axis_tdata/tvalid          signed trapezoid samples (never stalled)
//   threshold                    signed trigger level (crossing: sample > threshold)
//   peak_delay, holdoff          latched at each crossing
//   m_axis_tdata/tuser/tvalid/tready  energy word, crossing timestamp
//   pulse_count/reject_count/drop_count  saturating event counters
//   busy                         FSM not idle
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_IDLE     | waiting for a sample above threshold
// ST_ARMED    | crossed, counting valid samples toward the sample point
// ST_WAIT_LOW | captured, waiting for the trapezoid to fall back to threshold
// ST_HOLDOFF  | dead time after the pulse, no triggering
module trap_peak_capture
  import trap_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int TS_WIDTH   = DEF_TS_WIDTH
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] threshold,
  input  logic [CNT_WIDTH-1:0]  peak_delay,
  input  logic [CNT_WIDTH-1:0]  holdoff,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [TS_WIDTH-1:0]   m_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [31:0]           pulse_count,
  output logic [31:0]           reject_count,
  output logic [31:0]           drop_count,
  output logic                  busy
);

  trap_state_e state_q, state_d;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] hcnt_q, hcnt_d;
  logic [CNT_WIDTH-1:0] pd_lat_q, pd_lat_d;
  logic [CNT_WIDTH-1:0] ho_lat_q, ho_lat_d;
  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [TS_WIDTH-1:0]  ts_lat_q, ts_lat_d;
  logic [31:0]          pulse_q, pulse_d;
  logic [31:0]          reject_q, reject_d;
  logic [31:0]          drop_q, drop_d;

  logic                 sample_hi;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [CNT_WIDTH-1:0] hcnt_inc;
  logic                 capture;
  logic                 reject;
  logic                 loaded;
  logic                 dropped;

  assign sample_hi = $signed(s_axis_tdata) > $signed(threshold);
  assign cnt_inc   = cnt_q + 1'b1;
  assign hcnt_inc  = hcnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    pd_lat_d = pd_lat_q;
    ho_lat_d = ho_lat_q;
    ts_d     = ts_q;
    ts_lat_d = ts_lat_q;
    capture  = 1'b0;
    reject   = 1'b0;
    if (s_axis_tvalid) begin
      ts_d = ts_q + 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (sample_hi) begin
            ts_lat_d = ts_q;
            pd_lat_d = peak_delay;
            ho_lat_d = holdoff;
            cnt_d    = '0;
            if (peak_delay == '0) begin
              capture = 1'b1;
              state_d = ST_WAIT_LOW;
            end else begin
              state_d = ST_ARMED;
            end
          end
        end
        ST_ARMED: begin
          cnt_d = cnt_inc;
          if (!sample_hi) begin
            reject  = 1'b1;
            hcnt_d  = '0;
            // A zero holdoff means no dead time at all.
            state_d = (ho_lat_q == '0) ? ST_IDLE : ST_HOLDOFF;
          end else if (cnt_inc == pd_lat_q) begin
            capture = 1'b1;
            state_d = ST_WAIT_LOW;
          end
        end
        ST_WAIT_LOW: begin
          if (!sample_hi) begin
            hcnt_d  = '0;
            state_d = (ho_lat_q == '0) ? ST_IDLE : ST_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          hcnt_d = hcnt_inc;
          if (hcnt_inc == ho_lat_q) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ts_lat_d already holds the crossing timestamp when capturing on the crossing sample.
  axis_out_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .USER_WIDTH (TS_WIDTH)
  ) u_out (
    .clk           (clk),
    .aresetn       (aresetn),
    .load          (capture),
    .load_data     (s_axis_tdata),
    .load_user     (ts_lat_d),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .loaded        (loaded),
    .dropped       (dropped)
  );

  always_comb begin
    pulse_d  = sat_inc(pulse_q, loaded);
    reject_d = sat_inc(reject_q, reject);
    drop_d   = sat_inc(drop_q, dropped);
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      pd_lat_q <= '0;
      ho_lat_q <= '0;
      ts_q     <= '0;
      ts_lat_q <= '0;
      pulse_q  <= '0;
      reject_q <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      pd_lat_q <= pd_lat_d;
      ho_lat_q <= ho_lat_d;
      ts_q     <= ts_d;
      ts_lat_q <= ts_lat_d;
      pulse_q  <= pulse_d;
      reject_q <= reject_d;
      drop_q   <= drop_d;
    end
  end

  assign pulse_count  = pulse_q;
  assign reject_count = reject_q;
  assign drop_count   = drop_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_trap_peak_capture.sv
module tb_trap_peak_capture;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        aresetn;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic [31:0] threshold;
  logic [13:0] peak_delay;
  logic [13:0] holdoff;
  logic [31:0] m_tdata;
  logic [31:0] m_tuser;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] pulse_count;
  logic [31:0] reject_count;
  logic [31:0] drop_count;
  logic        busy;

  int tests    = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  trap_peak_capture dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .threshold     (threshold),
    .peak_delay    (peak_delay),
    .holdoff       (holdoff),
    .m_axis_tdata  (m_tdata),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .pulse_count   (pulse_count),
    .reject_count  (reject_count),
    .drop_count    (drop_count),
    .busy          (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Behavioural model: phase 0 quiet, 1 rising toward the sample point,
  // 2 on the flat top, 3 dead time. Output slot modelled as one optional word.
  int          phase;
  int          remaining;
  int          dead_left;
  int          m_ho;
  logic [31:0] ts;
  logic [31:0] m_ts;
  logic        exp_valid;
  logic [31:0] exp_data;
  logic [31:0] exp_user;
  logic [31:0] exp_pulse;
  logic [31:0] exp_reject;
  logic [31:0] exp_drop;

  function automatic void go_dead(input int n);
    if (n == 0) phase = 0;
    else begin
      phase     = 3;
      dead_left = n;
    end
  endfunction

  always @(posedge clk) begin : model
    bit cap;
    bit hi;
    cap = 1'b0;
    hi  = $signed(s_tdata) > $signed(threshold);
    if (!aresetn) begin
      phase = 0; remaining = 0; dead_left = 0; m_ho = 0;
      ts = 0; m_ts = 0;
      exp_valid = 1'b0; exp_data = 0; exp_user = 0;
      exp_pulse = 0; exp_reject = 0; exp_drop = 0;
    end else begin
      if (s_tvalid) begin
        case (phase)
          0: if (hi) begin
               m_ts = ts;
               m_ho = int'(holdoff);
               if (peak_delay == 14'd0) begin
                 cap = 1'b1; phase = 2;
               end else begin
                 remaining = int'(peak_delay); phase = 1;
               end
             end
          1: if (!hi) begin
               exp_reject = exp_reject + 1;
               go_dead(m_ho);
             end else begin
               remaining = remaining - 1;
               if (remaining == 0) begin cap = 1'b1; phase = 2; end
             end
          2: if (!hi) go_dead(m_ho);
          default: begin
            dead_left = dead_left - 1;
            if (dead_left == 0) phase = 0;
          end
        endcase
        ts = ts + 1;
      end
      if (cap) begin
        if (exp_valid && !m_tready) exp_drop = exp_drop + 1;
        else begin
          exp_valid = 1'b1; exp_data = s_tdata; exp_user = m_ts;
          exp_pulse = exp_pulse + 1;
        end
      end else if (exp_valid && m_tready) begin
        exp_valid = 1'b0;
      end
    end
  end

  // Words the DUT actually hands off (sampled before the edge updates).
  logic [31:0] got_data[$];
  logic [31:0] got_user[$];
  always @(posedge clk) begin
    if (aresetn && m_tvalid && m_tready) begin
      got_data.push_back(m_tdata);
      got_user.push_back(m_tuser);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("tvalid", {31'd0, m_tvalid}, {31'd0, exp_valid});
      if (exp_valid) begin
        check("tdata", m_tdata, exp_data);
        check("tuser", m_tuser, exp_user);
      end
      check("pulse_count", pulse_count, exp_pulse);
      check("reject_count", reject_count, exp_reject);
      check("drop_count", drop_count, exp_drop);
      check("busy", {31'd0, busy}, {31'd0, phase != 0});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int   stim[$];
  logic tv_hist[64];
  logic busy_hist[64];

  task automatic drive_point();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    @(posedge clk);
    #1;
    check("rst tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst pulse", pulse_count, 32'd0);
    check("rst reject", reject_count, 32'd0);
    check("rst drop", drop_count, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    drive_point();
    aresetn = 1'b1;
    got_data.delete();
    got_user.delete();
    chk_en = 1'b1;
  endtask

  task automatic run_stream(input int gap);
    for (int i = 0; i < stim.size(); i++) begin
      s_tdata  = stim[i];
      s_tvalid = 1'b1;
      @(posedge clk);
      #1;
      tv_hist[i]   = m_tvalid;
      busy_hist[i] = busy;
      drive_point();
      s_tvalid = 1'b0;
      s_tdata  = 32'd0;
      for (int g = 0; g < gap; g++) drive_point();
    end
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    for (int k = 0; k < n; k++) drive_point();
  endtask

  task automatic load_main();
    stim = '{0, 0, 200, 400, 600, 600, 300, 50, 0, 0, 0};
  endtask

  initial begin
    aresetn    = 1'b0;
    s_tdata    = 32'd0;
    s_tvalid   = 1'b0;
    threshold  = 32'd100;
    peak_delay = 14'd3;
    holdoff    = 14'd2;
    m_tready   = 1'b1;
    drive_point();

    // Basic capture; inputs change after the crossing to show only latched values matter.
    do_reset();
    load_main();
    fork
      run_stream(0);
      begin
        repeat (4) @(negedge clk);
        peak_delay = 14'd9;
        holdoff    = 14'd7;
      end
    join
    idle(3);
    check("s1 words", got_data.size(), 32'd1);
    if (got_data.size() >= 1) begin
      check("s1 tdata", got_data[0], 32'd600);
      check("s1 tuser", got_user[0], 32'd2);
    end
    check("s1 tvalid before cap", {31'd0, tv_hist[4]}, 32'd0);
    check("s1 tvalid after cap", {31'd0, tv_hist[5]}, 32'd1);
    check("s1 busy idx8", {31'd0, busy_hist[8]}, 32'd1);
    check("s1 busy idx9", {31'd0, busy_hist[9]}, 32'd0);
    check("s1 pulse", pulse_count, 32'd1);

    // Rejected pulse.
    peak_delay = 14'd3;
    holdoff    = 14'd2;
    do_reset();
    stim = '{0, 150, 200, 50, 0, 0, 0};
    run_stream(0);
    idle(2);
    check("s2 words", got_data.size(), 32'd0);
    check("s2 reject", reject_count, 32'd1);
    check("s2 pulse", pulse_count, 32'd0);
    check("s2 busy idx4", {31'd0, busy_hist[4]}, 32'd1);
    check("s2 busy idx5", {31'd0, busy_hist[5]}, 32'd0);

    // Gapped input: valid every third cycle.
    do_reset();
    load_main();
    run_stream(2);
    idle(3);
    check("s3 words", got_data.size(), 32'd1);
    if (got_data.size() >= 1) begin
      check("s3 tdata", got_data[0], 32'd600);
      check("s3 tuser", got_user[0], 32'd2);
    end
    check("s3 tvalid before cap", {31'd0, tv_hist[4]}, 32'd0);
    check("s3 tvalid after cap", {31'd0, tv_hist[5]}, 32'd1);

    // Backpressure: second capture dropped, first word held.
    m_tready = 1'b0;
    do_reset();
    stim = '{0, 200, 400, 600, 600, 300, 50, 0, 0, 200, 400, 600, 600, 50, 0, 0, 0};
    run_stream(0);
    idle(3);
    check("s4 held tvalid", {31'd0, m_tvalid}, 32'd1);
    check("s4 held tdata", m_tdata, 32'd600);
    check("s4 held tuser", m_tuser, 32'd1);
    check("s4 drop", drop_count, 32'd1);
    check("s4 pulse", pulse_count, 32'd1);
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    check("s4 tvalid after accept", {31'd0, m_tvalid}, 32'd0);
    check("s4 words", got_data.size(), 32'd1);
    if (got_data.size() >= 1) check("s4 tdata", got_data[0], 32'd600);
    drive_point();

    // Zero peak_delay and zero holdoff.
    peak_delay = 14'd0;
    holdoff    = 14'd0;
    do_reset();
    stim = '{0, 500, 0, 500, 0};
    run_stream(0);
    idle(2);
    check("s5 words", got_data.size(), 32'd2);
    if (got_data.size() >= 2) begin
      check("s5 tdata0", got_data[0], 32'd500);
      check("s5 tuser0", got_user[0], 32'd1);
      check("s5 tdata1", got_data[1], 32'd500);
      check("s5 tuser1", got_user[1], 32'd3);
    end
    check("s5 tvalid on crossing", {31'd0, tv_hist[1]}, 32'd1);

    // Reset mid-pulse with a word pending, then a normal pulse.
    peak_delay = 14'd3;
    holdoff    = 14'd2;
    m_tready   = 1'b0;
    do_reset();
    stim = '{0, 200, 400, 600, 600, 300, 50, 0, 0, 200, 400};
    run_stream(0);
    check("s6 pending tvalid", {31'd0, m_tvalid}, 32'd1);
    check("s6 armed busy", {31'd0, busy}, 32'd1);
    do_reset();
    m_tready = 1'b1;
    load_main();
    run_stream(0);
    idle(3);
    check("s6 words", got_data.size(), 32'd1);
    if (got_data.size() >= 1) begin
      check("s6 tdata", got_data[0], 32'd600);
      check("s6 tuser", got_user[0], 32'd2);
    end
    check("s6 pulse", pulse_count, 32'd1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
